// File: rtl/pool2x2_avg_if.sv
// Valid/ready stream and start/busy/done control bundle for the 2x2 average-pooling stage.
interface pool2x2_avg_if #(
  parameter int DATA_W = 8
) ();
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/pool2x2_avg.sv
// Streaming 2x2 average pooling: raster-order pixels in, floor(sum/4) of each 2x2 block out.
module pool2x2_avg #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  pool2x2_avg_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HW = IMG_W / 2;
  localparam int BW = (HW > 1) ? $clog2(HW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, nstate;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [BW-1:0]     bidx;
  logic              acc;
  logic              last_px;
  logic              load;
  logic              in_ready_c;
  logic              busy_c;

  logic [DATA_W-1:0] hold_p0;
  logic [DATA_W:0]   lb [HW];
  logic [DATA_W-1:0] out_data_p1;
  logic              vld_p1;
  logic              done_p1;

  function automatic logic [DATA_W:0] add_pair(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Floor of the four-pixel mean; the DATA_W+2 bit sum cannot overflow.
  function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W:0]   pair,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W+1:0] s;
    s = {1'b0, pair} + {2'b00, a} + {2'b00, b};
    return s[DATA_W+1:2];
  endfunction

  assign acc     = bus.in_valid && in_ready_c;
  assign last_px = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));
  assign load    = acc && row[0] && col[0];
  assign bidx    = BW'(col >> 1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (bus.start) nstate = RUN;
      RUN:     if (acc && last_px) nstate = FLUSH;
      FLUSH:   if (vld_p1 && bus.out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy_c     = (state == RUN) || (state == FLUSH);
    in_ready_c = (state == RUN) && (!vld_p1 || bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && bus.start) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage p0: hold the even-column pixel, fold even-row pairs into the line buffer.
  always_ff @(posedge clk) begin
    if (rst)                  hold_p0 <= '0;
    else if (acc && !col[0])  hold_p0 <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (acc && !row[0] && col[0]) lb[bidx] <= add_pair(hold_p0, bus.in_data);
  end

  // Stage p1: output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
    end else if (load) begin
      vld_p1      <= 1'b1;
      out_data_p1 <= avg4(lb[bidx], hold_p0, bus.in_data);
    end else if (bus.out_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) done_p1 <= 1'b0;
    else     done_p1 <= (state == FLUSH) && vld_p1 && bus.out_ready;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = out_data_p1;
  assign bus.done      = done_p1;

endmodule
